// File: rtl/countdown_display_driver.sv
// rtl/countdown_display_driver.sv - two-digit multiplexed 7-segment driver with blinking alarm and buzzer
module countdown_display_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 12500000,
  parameter int TONE_DIV       = 12500,
  parameter int LZ_BLANK       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] time_h,
  input  logic [3:0] time_l,
  input  logic       alarm,
  input  logic       mute,
  output logic [6:0] seg,
  output logic [1:0] digit_sel,
  output logic       buzzer,
  output logic [1:0] alarm_state
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = (TONE_DIV  > 1) ? $clog2(TONE_DIV)  : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_DIV - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2, MUTED = 2'd3} state_t;

  state_t          state;
  logic [SW-1:0]   scan_cnt;
  logic [BW-1:0]   blink_cnt;
  logic [TW-1:0]   tone_cnt;
  logic            digit_idx;
  logic [3:0]      lat_h;
  logic [3:0]      lat_l;
  logic [3:0]      cur_digit;
  logic            lz_blank;
  logic            blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Latches are refreshed only at frame start so both digits always come from one sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= 1'b0;
      lat_h     <= 4'd0;
      lat_l     <= 4'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= ~digit_idx;
      if (digit_idx) begin
        lat_h <= time_h;
        lat_l <= time_l;
      end
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign cur_digit = digit_idx ? lat_h : lat_l;
  assign lz_blank  = (LZ_BLANK != 0) && digit_idx && (lat_h == 4'd0) &&
                     (state != ON) && (state != MUTED);
  assign blank     = (state == OFF) || lz_blank;

  always_ff @(posedge clock) begin
    if (reset) begin
      seg       <= SEG_OFF;
      digit_sel <= DIG_OFF;
    end else if (blank) begin
      seg       <= SEG_OFF;
      digit_sel <= DIG_OFF;
    end else begin
      seg       <= decode(cur_digit) ^ SEG_OFF;
      digit_sel <= (digit_idx ? 2'b10 : 2'b01) ^ DIG_OFF;
    end
  end

  // Live alarm drop wins over mute and blink expiry in every state.
  always_ff @(posedge clock) begin
    if (reset || !alarm) begin
      state     <= IDLE;
      blink_cnt <= '0;
      tone_cnt  <= '0;
      buzzer    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= mute ? MUTED : ON;
          blink_cnt <= '0;
          tone_cnt  <= '0;
          buzzer    <= 1'b0;
        end
        ON: begin
          if (mute) begin
            state  <= MUTED;
            buzzer <= 1'b0;
          end else if (blink_cnt == BLINK_LAST) begin
            state     <= OFF;
            blink_cnt <= '0;
            tone_cnt  <= '0;
            buzzer    <= 1'b0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (tone_cnt == TONE_LAST) begin
              tone_cnt <= '0;
              buzzer   <= ~buzzer;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
          end
        end
        OFF: begin
          buzzer   <= 1'b0;
          tone_cnt <= '0;
          if (mute) begin
            state <= MUTED;
          end else if (blink_cnt == BLINK_LAST) begin
            state     <= ON;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
        default: begin
          state  <= MUTED;
          buzzer <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_state = state;

endmodule

// File: tb/tb_countdown_display_driver.sv
// tb/tb_countdown_display_driver.sv - randomized bench against a cycle-count reference model
module tb_countdown_display_driver;

  localparam int SCAN  = 4;
  localparam int BLINK = 16;
  localparam int TONE  = 2;

  logic       clock;
  logic       reset;
  logic [3:0] time_h;
  logic [3:0] time_l;
  logic       alarm;
  logic       mute;
  logic [6:0] seg;
  logic [1:0] digit_sel;
  logic       buzzer;
  logic [1:0] alarm_state;

  countdown_display_driver #(
    .SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .TONE_DIV(TONE),
    .LZ_BLANK(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .time_h(time_h), .time_l(time_l),
    .alarm(alarm), .mute(mute), .seg(seg), .digit_sel(digit_sel),
    .buzzer(buzzer), .alarm_state(alarm_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: display position derived from edges since reset, alarm from time spent in a phase.
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         n_edges;
  logic [3:0] mh, ml;
  int         ms;
  int         mc;
  logic [6:0] exp_seg;
  logic [1:0] exp_dsel;
  logic       exp_buz;
  int         exp_st;

  task automatic model_edge();
    bit         hi_slot;
    bit         hide;
    logic [3:0] d;
    if (reset) begin
      n_edges = 0; mh = 0; ml = 0; ms = 0; mc = 0;
      exp_seg = 7'h7F; exp_dsel = 2'b11; exp_buz = 1'b0; exp_st = 0;
      return;
    end
    hi_slot = ((n_edges / SCAN) % 2) == 1;
    d       = hi_slot ? mh : ml;
    hide    = (ms == 2) || (hi_slot && mh == 4'd0 && (ms == 0 || ms == 2));
    if (hide) begin
      exp_seg  = 7'h7F;
      exp_dsel = 2'b11;
    end else begin
      exp_seg  = ~((d <= 4'd9) ? seg_tab[d] : 7'h40);
      exp_dsel = hi_slot ? 2'b01 : 2'b10;
    end
    n_edges++;
    if (n_edges % (2 * SCAN) == 0) begin
      mh = time_h;
      ml = time_l;
    end
    if (!alarm) begin
      ms = 0; mc = 0;
    end else if (ms == 0) begin
      ms = mute ? 3 : 1; mc = 0;
    end else if (ms == 1 || ms == 2) begin
      if (mute) ms = 3;
      else begin
        mc++;
        if (mc == BLINK) begin
          ms = (ms == 1) ? 2 : 1;
          mc = 0;
        end
      end
    end
    exp_buz = (ms == 1) ? (((mc / TONE) % 2) == 1) : 1'b0;
    exp_st  = ms;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("seg", seg, exp_seg);
    check("digit_sel", digit_sel, exp_dsel);
    check("buzzer", buzzer, exp_buz);
    check("alarm_state", alarm_state, exp_st);
    @(negedge clock);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    reset = 1'b1; time_h = 4'd0; time_l = 4'd0; alarm = 1'b0; mute = 1'b0;
    run(3);
    reset = 1'b0;

    time_h = 4'd2; time_l = 4'd0;
    run(20);

    begin
      int budget = 64;
      while (!(((n_edges / SCAN) % 2) == 1 && (n_edges % SCAN) == 1) && budget > 0) begin
        tick();
        budget--;
      end
      check("hi_slot_wait", budget > 0, 1);
    end
    time_l = 4'd9;
    run(20);

    time_h = 4'd0; time_l = 4'd7;
    run(20);
    time_h = 4'hC;
    run(20);

    time_h = 4'd0; time_l = 4'd0;
    run(10);
    alarm = 1'b1;
    run(50);

    mute = 1'b1;
    run(1);
    mute = 1'b0;
    run(10);
    alarm = 1'b0;
    run(5);

    alarm = 1'b1; mute = 1'b1;
    run(1);
    mute = 1'b0;
    run(10);
    alarm = 1'b0;
    run(3);
    alarm = 1'b1;
    run(5);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(10);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        time_h = 4'($urandom_range(0, 15));
        time_l = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) time_h = 4'd0;
      end
      if ($urandom_range(0, 39) == 0) alarm = ~alarm;
      mute  = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; mute = 1'b0;
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_display_driver.md
Name: countdown_display_driver

Overview:
- Consumer end of the countdown counter's output interface: takes the two BCD time digits and the zero-reached alarm level, drives a multiplexed two-digit 7-segment display and a piezo buzzer.
- Scans the digits time-multiplexed and latches the input digits once per scan frame, so a digit pair is never shown mid-update (no tearing).
- When the alarm is active, the display blinks and the buzzer plays a gated tone; a mute input silences the buzzer.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays selected (min 2)
- BLINK_DIV, 12500000, clock cycles per alarm ON/OFF half-period (min 2)
- TONE_DIV, 12500, clock cycles per buzzer tone half-period (min 1)
- LZ_BLANK, 1, 1 = blank a leading zero in the high digit
- SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (common-anode panel)
- DIG_ACTIVE_LOW, 1, 1 = digit_sel outputs inverted

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- time_h  in  4  BCD high digit from counter
- time_l  in  4  BCD low digit from counter
- alarm  in  1  level, 1 while count is zero
- mute  in  1  level or pulse, silences buzzer for current alarm
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- digit_sel  out  2  [1]=high digit, [0]=low digit; one-hot when lit; polarity per DIG_ACTIVE_LOW
- buzzer  out  1  square-wave drive, active high
- alarm_state  out  2  current FSM state, for debug and test

Behaviour:
- Reset, all outputs registered:
  - seg and digit_sel are inactive (all segments/digits off at the port polarity).
  - buzzer=0, FSM=IDLE.
  - Latched digits = 0, scan/blink/tone counters = 0, digit index = 0 (low digit).
- Reset asserted mid-alarm returns everything to reset values on the next edge.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - At wrap, the digit index toggles.
  - When the index goes 1->0 (frame start), time_h/time_l are sampled into the latches.
  - The first latch after reset occurs at the first 1->0 wrap.
- Output latency: seg/digit_sel update one clock after the index changes.
- Decode, active-high encoding before the polarity inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Digits A-F (non-BCD) display a dash = 40.
- Leading zero blank: if LZ_BLANK=1 and the latched high digit is 0, high-digit slots drive digit_sel inactive and seg off. The blank is suppressed while the FSM is ON or MUTED, so "00" is shown during the alarm.
- FSM states (alarm_state encoding): IDLE=0, ON=1, OFF=2, MUTED=3.
  - IDLE: alarm=1 -> ON, or MUTED if mute=1 in the same cycle. blink_cnt is cleared on entry to ON.
  - ON: digits lit, buzzer toggles every TONE_DIV cycles starting from 0. After BLINK_DIV cycles -> OFF. mute=1 -> MUTED.
  - OFF: digits blank (digit_sel inactive), buzzer=0, tone counter held at 0. After BLINK_DIV cycles -> ON. mute=1 -> MUTED.
  - MUTED: digits lit steady, buzzer=0.
  - Any state: alarm=0 -> IDLE on the next edge. This has priority over mute and over blink expiry.
  - mute in IDLE is ignored.
- The FSM reacts to the live alarm input, not to a latched value; the display content still comes from the frame latches.
- Counter widths: clog2 of each divisor; all wraps are exact, with no off-by-one.

Test Plan:
All scenarios use SCAN_DIV=4, BLINK_DIV=16, TONE_DIV=2, both polarity params =1, LZ_BLANK=1.
1. Reset, then time_h=2, time_l=0, alarm=0 for 20 cycles:
   - After the first frame, low slot shows seg=7'h40 ("0" inverted) with digit_sel=2'b10.
   - High slot shows seg=7'h24 ("2") with digit_sel=2'b01.
   - Each slot lasts 4 cycles.
2. Change time_l 0->9 in the middle of a high-digit slot:
   - Displayed low digit stays "0" until the next frame start.
   - Then it shows seg=7'h10.
3. time_h=0, time_l=7, alarm=0:
   - High slot has digit_sel=2'b11 and seg=7'h7F (blanked).
   - Low slot shows seg=7'h78.
   - time_h=4'hC displays dash, seg=7'h3F.
4. time=00 with alarm rising:
   - alarm_state goes 0->1 next edge; buzzer toggles every 2 cycles for 16 cycles.
   - Then state 2 for 16 cycles with buzzer=0 and digit_sel=2'b11.
   - Then back to state 1.
   - High digit "0" is shown (not blanked) during state 1.
5. During ON, pulse mute for 1 cycle:
   - State becomes 3 next edge, buzzer=0, digits lit steady.
   - Deassert alarm: state 0 next edge.
6. alarm and mute asserted together from IDLE -> state 3. Assert reset mid-ON -> state 0, buzzer=0, outputs inactive next edge.
